// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared FSM encoding and limits for the bit-serial adder.
// SERIAL_ADDER_SUB_EN enables subtract mode (A-B via inverted B and carry preload).
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int MAX_WIDTH = 32;

`ifdef SERIAL_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// fullAdder: single-bit full-adder cell shared across the team's serial datapaths.
module fullAdder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial add through one fullAdder, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to honour the sub input (A-B, cout_out=1 means no borrow).
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sub,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
    logic [CW-1:0]    count_q;
    logic             carry_q, sub_q, busy_q, valid_q, cout_q;
    logic             b_bit_d, sum_bit_d, carry_d;
    logic [WIDTH-1:0] acc_d;

    // Operands shift right so bit[count] is always presented at position 0.
    assign b_bit_d = b_q[0] ^ sub_q;
    assign acc_d   = {sum_bit_d, acc_q[WIDTH-1:1]};

    fullAdder u_fa (
        .a_i   (a_q[0]),
        .b_i   (b_bit_d),
        .cin_i (carry_q),
        .sum_o (sum_bit_d),
        .cout_o(carry_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        sub_q   <= SUB_EN & sub;
                        carry_q <= SUB_EN & sub;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    acc_q   <= acc_d;
                    carry_q <= carry_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        sum_q   <= acc_d;
                        cout_q  <= carry_d;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign sum_out      = sum_q;
    assign cout_out     = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: randomized self-checking bench against an arithmetic reference model.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         sub = 1'b0;
    logic         busy, result_valid, cout_out;
    logic [W-1:0] sum_out;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] exp_sum = '0;
    logic         exp_cout = 1'b0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a_in        (a_in),
        .b_in        (b_in),
        .sub         (sub),
        .busy        (busy),
        .result_valid(result_valid),
        .sum_out     (sum_out),
        .cout_out    (cout_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: true unsigned sum, or difference with no-borrow flag.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] r, output logic c);
        int unsigned t;
`ifdef SERIAL_ADDER_SUB_EN
        if (s) begin
            r = W'(a - b);
            c = (a >= b);
        end else begin
            t = int'(a) + int'(b);
            r = W'(t);
            c = (t >= (1 << W));
        end
`else
        t = int'(a) + int'(b);
        r = W'(t);
        c = (t >= (1 << W));
`endif
    endtask

    // Issue one op from IDLE and check every cycle until back in IDLE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input bit hold, input bit scramble);
        logic [W-1:0] r;
        logic         c;
        model(a, b, s, r, c);
        a_in  = a;
        b_in  = b;
        sub   = s;
        start = 1'b1;
        for (int k = 0; k <= W; k++) begin
            @(posedge clk);
            #1;
            if (scramble) begin
                a_in = W'($urandom);
                b_in = W'($urandom);
                sub  = 1'($urandom);
            end
            start = hold ? 1'b1 : 1'($urandom);
            if (k == W) begin
                exp_sum  = r;
                exp_cout = c;
            end
            check("busy", 32'(busy), 32'd1);
            check("valid", 32'(result_valid), (k == W) ? 32'd1 : 32'd0);
            check("sum", 32'(sum_out), 32'(exp_sum));
            check("cout", 32'(cout_out), 32'(exp_cout));
        end
        @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(result_valid), 32'd0);
        check("idle_sum", 32'(sum_out), 32'(exp_sum));
        check("idle_cout", 32'(cout_out), 32'(exp_cout));
        if (!hold) start = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_sum", 32'(sum_out), 32'd0);
        check("rst_cout", 32'(cout_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(8'h5A, 8'h33, 1'b0, 1'b0, 1'b1);
        check("5A+33_sum", 32'(sum_out), 32'h8D);
        check("5A+33_cout", 32'(cout_out), 32'd0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        check("FF+01_sum", 32'(sum_out), 32'h00);
        check("FF+01_cout", 32'(cout_out), 32'd1);
        run_op(8'h10, 8'h01, 1'b1, 1'b0, 1'b1);
`ifdef SERIAL_ADDER_SUB_EN
        check("10-01_sum", 32'(sum_out), 32'h0F);
        check("10-01_cout", 32'(cout_out), 32'd1);
`else
        check("10+01_sum", 32'(sum_out), 32'h11);
        check("10+01_cout", 32'(cout_out), 32'd0);
`endif
        run_op(8'h01, 8'h02, 1'b1, 1'b0, 1'b1);
`ifdef SERIAL_ADDER_SUB_EN
        check("01-02_sum", 32'(sum_out), 32'hFF);
        check("01-02_cout", 32'(cout_out), 32'd0);
`else
        check("01+02_sum", 32'(sum_out), 32'h03);
        check("01+02_cout", 32'(cout_out), 32'd0);
`endif

        // Start held high: back-to-back ops every W+2 cycles.
        for (int i = 0; i < 3; i++) begin
            run_op(8'h01, 8'h01, 1'b0, 1'b1, 1'b1);
            check("hold_sum", 32'(sum_out), 32'h02);
        end
        start = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of an operation.
        a_in  = 8'hC3;
        b_in  = 8'h7E;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(result_valid), 32'd0);
        check("mid_rst_sum", 32'(sum_out), 32'd0);
        check("mid_rst_cout", 32'(cout_out), 32'd0);
        exp_sum  = '0;
        exp_cout = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < W + 3; k++) begin
            @(posedge clk);
            #1;
            check("post_rst_valid", 32'(result_valid), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
        end

        for (int i = 0; i < 25; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
